// File: rtl/imem_loader.sv
// Purpose: loads an instruction-memory image from a byte stream (COUNT, HI/LO pairs, XOR checksum) while holding the core in reset.
// Latency: one im_we pulse in the cycle after each LO byte is accepted; done pulses the cycle after a matching checksum byte.
// Backpressure: rx_ready is high only while a byte is expected (COUNT/HI/LO/CHECK); an idle gap that reaches TIMEOUT_CYCLES-1 aborts to ERR.
// Ports:
//   clk, rstn                    - clock, async active-low reset
//   load_start                   - one-cycle load request (honoured in IDLE/ERR only)
//   rx_data, rx_valid, rx_ready  - byte stream handshake
//   im_we, im_addr, im_wdata     - instruction-memory write port (addr/wdata registered)
//   core_rstn                    - active-low reset to the fetch/decode core
//   busy, done, err              - status: load in progress, success pulse, sticky failure
module imem_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [15:0] im_wdata,
  output logic        core_rstn,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  count_n;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic [7:0]  index;
  logic [15:0] idle_cnt;
  logic        waiting;
  logic        accept;
  logic        start;
  logic        timeout;

  assign waiting = (state == COUNT) || (state == HI) || (state == LO) || (state == CHECK);
  assign accept  = rx_valid && waiting;
  assign start   = load_start && ((state == IDLE) || (state == ERR));
  // Fires in the cycle whose idle increment would bring the counter to the limit,
  // so ERR is the state seen once the counter would read TIMEOUT_CYCLES-1.
  assign timeout = waiting && !accept && ((idle_cnt + 16'd1) == IDLE_LIMIT);

  // Status outputs are pure decodes of the state register, so reset drives
  // them to their idle values immediately without waiting for a clock.
  assign rx_ready  = waiting;
  assign im_we     = (state == WRITE);
  assign busy      = waiting || (state == WRITE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign core_rstn = !(busy || (state == ERR));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load_start) state_nxt = COUNT;
      COUNT: begin
        if (timeout)     state_nxt = ERR;
        else if (accept) state_nxt = HI;
      end
      HI: begin
        if (timeout)     state_nxt = ERR;
        else if (accept) state_nxt = LO;
      end
      LO: begin
        if (timeout)     state_nxt = ERR;
        else if (accept) state_nxt = WRITE;
      end
      // Last word written when the index has reached N; the index never wraps.
      WRITE: state_nxt = (index == count_n) ? CHECK : HI;
      CHECK: begin
        if (timeout)     state_nxt = ERR;
        else if (accept) state_nxt = (rx_data == csum) ? DONE : ERR;
      end
      DONE:  state_nxt = IDLE;
      ERR:   if (load_start) state_nxt = COUNT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_n  <= 8'h00;
      hi_byte  <= 8'h00;
      csum     <= 8'h00;
      index    <= 8'h00;
      idle_cnt <= 16'h0000;
      im_addr  <= 8'h00;
      im_wdata <= 16'h0000;
    end else if (start) begin
      csum     <= 8'h00;
      index    <= 8'h00;
      idle_cnt <= 16'h0000;
    end else begin
      if (accept) begin
        idle_cnt <= 16'h0000;
      end else if (waiting) begin
        idle_cnt <= idle_cnt + 16'd1;
      end

      // The checksum byte itself is not folded into the running XOR.
      if (accept && (state != CHECK)) begin
        csum <= csum ^ rx_data;
      end

      if (accept && (state == COUNT)) begin
        count_n <= rx_data;
      end

      if (accept && (state == HI)) begin
        hi_byte <= rx_data;
      end

      // Address and data are captured with the LO byte so they are already
      // registered and stable for the whole WRITE cycle.
      if (accept && (state == LO)) begin
        im_wdata <= {hi_byte, rx_data};
        im_addr  <= index;
      end

      if ((state == WRITE) && (index != count_n)) begin
        index <= index + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: directed self-checking bench for imem_loader (nominal, bad checksum, full image, timeout, backpressure, mid-load reset).
// Latency: inputs driven and outputs sampled on the falling edge; the write monitor samples 2 ns after the rising edge.
// Backpressure: bytes are held valid until rx_ready, with optional random gaps kept below the idle timeout.
module tb_imem_loader;

  logic        clk;
  logic        rstn;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic        core_rstn;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [23:0] wr_log[$];
  logic [7:0]  stream[$];
  int          we_cnt = 0;
  int          done_cnt = 0;

  imem_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_rstn  (core_rstn),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/done monitor, offset from both the rising edge and the falling-edge stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (im_we === 1'b1) begin
        wr_log.push_back({im_addr, im_wdata});
        we_cnt++;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic clear_log();
    wr_log.delete();
    we_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte_stall: rx_ready=%b for byte %h, required 1 within 100 cycles", rx_ready, b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drive_stream(input int max_gap);
    foreach (stream[i]) send_byte(stream[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    checks++;
    if ({rx_ready, im_we, core_rstn, busy, done, err} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_status: got %b required 001000", {rx_ready, im_we, core_rstn, busy, done, err});
    end
    checks++;
    if ({im_addr, im_wdata} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_addr_data: got %h required 000000", {im_addr, im_wdata});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, core_rstn, err} !== 3'b010) begin
      errors++;
      $display("FAIL reset_release_idle: got %b required 010", {busy, core_rstn, err});
    end
  endtask

  task automatic test_nominal();
    clear_log();
    stream = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    start_load();
    checks++;
    if ({busy, core_rstn, rx_ready} !== 3'b101) begin
      errors++;
      $display("FAIL nominal_enter_count: got %b required 101", {busy, core_rstn, rx_ready});
    end
    drive_stream(0);
    checks++;
    if ({done, core_rstn, err} !== 3'b110) begin
      errors++;
      $display("FAIL nominal_done: got %b required 110", {done, core_rstn, err});
    end
    checks++;
    if (wr_log.size() !== 2 || wr_log[0] !== 24'h001234 || wr_log[1] !== 24'h01ABCD) begin
      errors++;
      $display("FAIL nominal_writes: got n=%0d %h %h required n=2 001234 01ABCD", wr_log.size(), wr_log[0], wr_log[1]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_cnt !== 1 || core_rstn !== 1'b1) begin
      errors++;
      $display("FAIL nominal_done_pulse: done=%b count=%0d core_rstn=%b required 0 1 1", done, done_cnt, core_rstn);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    stream = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    start_load();
    drive_stream(0);
    repeat (3) @(negedge clk);
    checks++;
    if ({err, core_rstn, done, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL badsum_err: got %b required 1000", {err, core_rstn, done, busy});
    end
    checks++;
    if (we_cnt !== 2 || wr_log[0] !== 24'h001234 || wr_log[1] !== 24'h01ABCD || done_cnt !== 0) begin
      errors++;
      $display("FAIL badsum_writes: we=%0d %h %h done=%0d required 2 001234 01ABCD 0", we_cnt, wr_log[0], wr_log[1], done_cnt);
    end
    clear_log();
    stream = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    start_load();
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL badsum_restart: err,busy=%b required 01", {err, busy});
    end
    drive_stream(0);
    checks++;
    if ({done, err, core_rstn} !== 3'b101 || we_cnt !== 2) begin
      errors++;
      $display("FAIL badsum_recover: done,err,core_rstn=%b we=%0d required 101 2", {done, err, core_rstn}, we_cnt);
    end
  endtask

  task automatic test_full_image();
    logic [7:0] sum;
    int bad;
    clear_log();
    stream.delete();
    stream.push_back(8'hFF);
    sum = 8'hFF;
    for (int i = 0; i < 256; i++) begin
      stream.push_back(8'(i));
      stream.push_back(~8'(i));
      sum = sum ^ 8'(i) ^ ~8'(i);
    end
    stream.push_back(sum);
    start_load();
    drive_stream(0);
    checks++;
    if (done !== 1'b1 || we_cnt !== 256) begin
      errors++;
      $display("FAIL full_count: done=%b we=%0d required 1 256", done, we_cnt);
    end
    bad = 0;
    foreach (wr_log[k]) if (wr_log[k] !== {8'(k), 8'(k), ~8'(k)}) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_contents: %0d wrong entries, required 0", bad);
    end
    checks++;
    if (wr_log.size() == 0 || wr_log[wr_log.size()-1] !== 24'hFFFF00) begin
      errors++;
      $display("FAIL full_last: got %h required FFFF00", (wr_log.size() == 0) ? 24'hxxxxxx : wr_log[wr_log.size()-1]);
    end
  endtask

  task automatic test_timeout();
    clear_log();
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    // Now on the falling edge just after the HI acceptance.
    repeat (14) @(negedge clk);
    checks++;
    if ({busy, err} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_early: busy,err=%b after 14 idle cycles required 10", {busy, err});
    end
    @(negedge clk);
    checks++;
    if ({busy, err, core_rstn} !== 3'b010) begin
      errors++;
      $display("FAIL timeout_err: busy,err,core_rstn=%b after 15 idle cycles required 010", {busy, err, core_rstn});
    end
    checks++;
    if (we_cnt !== 0) begin
      errors++;
      $display("FAIL timeout_no_write: we=%0d required 0", we_cnt);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    start_load();
    send_byte(8'h01, 2);
    // In HI with no byte offered: this request must be ignored.
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    stream = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    drive_stream(6);
    checks++;
    if ({done, err, core_rstn} !== 3'b101) begin
      errors++;
      $display("FAIL bp_done: done,err,core_rstn=%b required 101", {done, err, core_rstn});
    end
    checks++;
    if (wr_log.size() !== 2 || wr_log[0] !== 24'h001234 || wr_log[1] !== 24'h01ABCD) begin
      errors++;
      $display("FAIL bp_writes: got n=%0d %h %h required n=2 001234 01ABCD", wr_log.size(), wr_log[0], wr_log[1]);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    // In LO with im_addr/im_wdata still holding the previous image's last write.
    rstn = 1'b0;
    #1;
    checks++;
    if ({rx_ready, im_we, core_rstn, busy, done, err} !== 6'b001000 || {im_addr, im_wdata} !== 24'h000000) begin
      errors++;
      $display("FAIL midreset_outputs: status=%b addr_data=%h required 001000 000000",
               {rx_ready, im_we, core_rstn, busy, done, err}, {im_addr, im_wdata});
    end
    rx_data  = 8'h34;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    rstn     = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (we_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_write: we=%0d busy=%b required 0 0", we_cnt, busy);
    end
    stream = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    start_load();
    drive_stream(0);
    checks++;
    if (done !== 1'b1 || wr_log.size() !== 2 || wr_log[0] !== 24'h001234 || wr_log[1] !== 24'h01ABCD) begin
      errors++;
      $display("FAIL midreset_reload: done=%b n=%0d %h %h required 1 2 001234 01ABCD", done, wr_log.size(), wr_log[0], wr_log[1]);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    load_start = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_full_image();
    test_timeout();
    test_backpressure();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL use parameter TIMEOUT_CYCLES, default 1024, giving the maximum number of idle cycles allowed between accepted bytes during a load (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port load_start, input, 1, one-cycle request to begin a load.
REQ-005 The block SHALL have port rx_data, input, 8, incoming byte.
REQ-006 The block SHALL have port rx_valid, input, 1, rx_data valid.
REQ-007 The block SHALL have port rx_ready, output, 1, loader accepts a byte this cycle.
REQ-008 The block SHALL have port im_we, output, 1, instruction-memory write strobe.
REQ-009 The block SHALL have port im_addr, output, 8, instruction-memory word address.
REQ-010 The block SHALL have port im_wdata, output, 16, instruction word to write.
REQ-011 The block SHALL have port core_rstn, output, 1, active-low reset to the fetch/decode core.
REQ-012 The block SHALL have port busy, output, 1, load in progress.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse on successful load.
REQ-014 The block SHALL have port err, output, 1, sticky load-failure flag.

Function
REQ-015 The block SHALL implement states IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR.
REQ-016 A byte SHALL be accepted only in a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 exactly in COUNT, HI, LO, CHECK.
REQ-017 load_start=1 in IDLE or ERR SHALL move to COUNT next cycle, clear err, clear the checksum and word index to 0, and drive core_rstn=0; load_start SHALL be ignored in all other states.
REQ-018 The COUNT byte N SHALL define N+1 words to load (1..256); COUNT -> HI on acceptance.
REQ-019 HI byte acceptance SHALL latch the upper instruction byte and move to LO; LO byte acceptance SHALL latch the lower byte and move to WRITE.
REQ-020 In WRITE, im_we SHALL be 1 for exactly one cycle with im_addr = word index and im_wdata = {hi, lo}; im_we SHALL be 0 in every other state.
REQ-021 After WRITE, the block SHALL go to CHECK if word index = N, else increment the index and go to HI; the index SHALL never wrap, and no write beyond address N SHALL occur.
REQ-022 The checksum SHALL be the 8-bit XOR of the COUNT byte and every data byte; a CHECK byte equal to it -> DONE, else -> ERR.
REQ-023 DONE SHALL last one cycle with done=1, core_rstn=1, then return to IDLE.
REQ-024 ERR SHALL hold err=1 and core_rstn=0 until the next accepted load_start; writes already performed SHALL NOT be undone.
REQ-025 A 16-bit idle counter SHALL clear on entry to COUNT and on every accepted byte, increment each cycle in COUNT/HI/LO/CHECK without acceptance, and force ERR when it reaches TIMEOUT_CYCLES-1.
REQ-026 busy SHALL be 1 in COUNT, HI, LO, WRITE, CHECK and 0 otherwise.
REQ-027 Outputs im_addr and im_wdata SHALL be registered; their values outside WRITE are don't-care.

Reset
REQ-028 On rstn=0, regardless of state or clock, the block SHALL immediately enter IDLE with rx_ready=0, im_we=0, im_addr=0, im_wdata=0, core_rstn=1, busy=0, done=0, err=0, checksum, index and idle counter = 0.
REQ-029 Reset asserted mid-load SHALL abandon the load with no further im_we pulse; core_rstn=1 after reset releases the core on the existing image.

Verification
REQ-030 Nominal: load_start, bytes 01,12,34,AB,CD,41 -> writes addr 00=1234, addr 01=ABCD, one done pulse, core_rstn=1, err=0.
REQ-031 Bad checksum: same stream ending 40 -> both writes occur, err=1, core_rstn=0, no done; a later good load clears err.
REQ-032 Full image: N=FF, 256 words -> last write at im_addr=FF, exactly 256 im_we pulses, no wrap write at 00.
REQ-033 Timeout: TIMEOUT_CYCLES=16, stop rx_valid after a HI byte -> ERR entered 15 cycles after the last acceptance, no im_we.
REQ-034 Backpressure/ignored start: rx_valid gapped randomly and load_start pulsed during HI -> identical writes to the nominal case, load not restarted.
REQ-035 Reset mid-load: rstn low during LO -> all outputs at reset values asynchronously, no im_we, next load_start succeeds normally.
